fft_stage_sequencer: RTL and testbench

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_stage_sequencer_if.sv | 37 +++
 rtl/fft_delay_line.sv | 29 ++
 rtl/fft_stage_sequencer.sv | 117 +++++++++++
 tb/tb_fft_stage_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: default sizing, the
// FSM state encoding and the stage number codes.
package fft_pkg;

  localparam int NUMSTAGES_DEF = 5;  // log2 of the FFT point count
  localparam int WR_LAT_DEF    = 2;  // butterfly read-to-write latency

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [2:0] STAGE0 = 3'd0;
  localparam logic [2:0] STAGE1 = 3'd1;
  localparam logic [2:0] STAGE2 = 3'd2;
  localparam logic [2:0] STAGE3 = 3'd3;
  localparam logic [2:0] STAGE4 = 3'd4;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control/status bundle between a transform requester (master) and the
// stage sequencer (slave). The stall line exists only when
// FFT_SEQ_STALL_EN is defined.
interface fft_stage_sequencer_if #(
  parameter int NUMSTAGES = fft_pkg::NUMSTAGES_DEF
);
  localparam int CW = NUMSTAGES - 2;

  logic          start;
`ifdef FFT_SEQ_STALL_EN
  logic          stall;
`endif
  logic [CW-1:0] counter;
  logic [2:0]    stage_num;
  logic          rd_en;
  logic [CW-1:0] wr_counter;
  logic          wr_en;
  logic          busy;
  logic          done;

`ifdef FFT_SEQ_STALL_EN
  modport master (output start, output stall,
                  input counter, input stage_num, input rd_en,
                  input wr_counter, input wr_en, input busy, input done);
  modport slave  (input start, input stall,
                  output counter, output stage_num, output rd_en,
                  output wr_counter, output wr_en, output busy, output done);
`else
  modport master (output start,
                  input counter, input stage_num, input rd_en,
                  input wr_counter, input wr_en, input busy, input done);
  modport slave  (input start,
                  output counter, output stage_num, output rd_en,
                  output wr_counter, output wr_en, output busy, output done);
`endif

endinterface

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear. Used to derive the
// write-side strobe/index from the read side; shifts every cycle.
module fft_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;

  // next shift state: new sample enters slot 0, others move up one
  always_comb begin
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end

  // shift register; clearing it drops any in-flight writes on reset
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: walks NUMSTAGES stages of 2^(NUMSTAGES-2) butterfly
// reads each, inserting a WR_LAT-cycle drain between stages so the last
// write of a stage lands before the next stage reads.
// Optional feature macro: FFT_SEQ_STALL_EN adds a stall input that
// freezes the read side while in RUN.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int NUMSTAGES = NUMSTAGES_DEF,
  parameter int WR_LAT    = WR_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_stage_sequencer_if.slave  bus
);

  localparam int          CW         = NUMSTAGES - 2;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [2:0]  LAST_STAGE = 3'(NUMSTAGES - 1);
  localparam logic [2:0]  DRAIN_LAST = 3'(WR_LAT - 1);

  seq_state_e    state_q;
  logic [CW-1:0] counter_q;
  logic [2:0]    stage_q;
  logic [2:0]    drain_q;
  logic          rd_en_q;
  logic          busy_q;
  logic          done_q;
  logic          stall_w;

`ifdef FFT_SEQ_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  // sequencer FSM; all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      stage_q   <= STAGE0;
      drain_q   <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            counter_q <= '0;
            stage_q   <= STAGE0;
          end
        end
        RUN: begin
          if (stall_w) begin
            // hold the index; the read already issued is not repeated
            rd_en_q <= 1'b0;
          end else if (counter_q == CNT_MAX) begin
            state_q   <= DRAIN;
            counter_q <= '0;
            rd_en_q   <= 1'b0;
            drain_q   <= '0;
          end else begin
            counter_q <= counter_q + CW'(1);
            rd_en_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            if (stage_q < LAST_STAGE) begin
              stage_q <= stage_q + 3'd1;
              state_q <= RUN;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          stage_q <= STAGE0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [CW:0] wr_q;

  fft_delay_line #(
    .WIDTH (CW + 1),
    .DEPTH (WR_LAT)
  ) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({rd_en_q, counter_q}),
    .q_o (wr_q)
  );

  assign bus.counter    = counter_q;
  assign bus.stage_num  = stage_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wr_en      = wr_q[CW];
  assign bus.wr_counter = wr_q[CW-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: the expected per-cycle output
// trace of each scenario is queued before it runs and popped each cycle.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int NS = 5;
  localparam int WL = 2;
  localparam int CW = NS - 2;
  localparam int NB = 1 << CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.NUMSTAGES(NS)) bus ();

  fft_stage_sequencer #(.NUMSTAGES(NS), .WR_LAT(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rd;
    logic [CW-1:0] cnt;
    logic [2:0]    stg;
    logic          wr;
    logic [CW-1:0] wcnt;
  } exp_t;

  exp_t        q[$];
  logic [CW:0] hist[WL];  // expected {rd,cnt} history, [0] = newest
  int          nchk  = 0;
  int          nfail = 0;

  function automatic void clr_hist();
    for (int i = 0; i < WL; i++) hist[i] = '0;
  endfunction

  function automatic void push(logic busy, logic done, logic rd, int cnt, int stg);
    exp_t e;
    e.busy = busy;
    e.done = done;
    e.rd   = rd;
    e.cnt  = CW'(cnt);
    e.stg  = 3'(stg);
    {e.wr, e.wcnt} = hist[WL-1];
    for (int i = WL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {rd, CW'(cnt)};
    q.push_back(e);
  endfunction

  // one full transform; optional extra stalled cycles after read (st_s, st_c)
  function automatic void push_xfer(int st_s, int st_c, int st_len);
    for (int s = 0; s < NS; s++) begin
      for (int c = 0; c < NB; c++) begin
        push(1, 0, 1, c, s);
        if (s == st_s && c == st_c)
          for (int k = 0; k < st_len; k++) push(1, 0, 0, c, s);
      end
      for (int d = 0; d < WL; d++) push(1, 0, 0, 0, s);
    end
    push(1, 1, 0, 0, NS - 1);
  endfunction

  function automatic void push_idle(int n);
    for (int k = 0; k < n; k++) push(0, 0, 0, 0, 0);
  endfunction

  // pop/compare one entry per cycle until the queue empties
  task automatic run_q(string name, int start_lo_at, int stall_at, int stall_len, int rst_at);
    int   i;
    exp_t e, a;
    i = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      if (i == start_lo_at) bus.start = 1'b0;
`ifdef FFT_SEQ_STALL_EN
      bus.stall = (stall_len > 0) && (i >= stall_at) && (i < stall_at + stall_len);
`endif
      e = q.pop_front();
      a.busy = bus.busy;   a.done = bus.done;   a.rd = bus.rd_en;
      a.cnt  = bus.counter; a.stg = bus.stage_num;
      a.wr   = bus.wr_en;  a.wcnt = bus.wr_counter;
      nchk++;
      if (a !== e) begin
        nfail++;
        $display("FAIL %s cyc %0d: got busy=%b done=%b rd=%b cnt=%0d stg=%0d wr=%b wcnt=%0d, want busy=%b done=%b rd=%b cnt=%0d stg=%0d wr=%b wcnt=%0d",
                 name, i, a.busy, a.done, a.rd, a.cnt, a.stg, a.wr, a.wcnt,
                 e.busy, e.done, e.rd, e.cnt, e.stg, e.wr, e.wcnt);
      end
      if (i == rst_at) begin
        rst = 1'b1;
        q.delete();
      end
      i++;
    end
`ifdef FFT_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
    if (stall_at < -1) $display("unused %0d", stall_len);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;  // must be ignored while in reset
    clr_hist();
    push_idle(3);
    run_q("reset", 99, -1, 0, -1);
    bus.start = 1'b0;
    rst = 1'b0;
    push_idle(2);
    run_q("post_reset_idle", 99, -1, 0, -1);
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.start = 1'b1;
    clr_hist();
    push_xfer(-1, 0, 0);
    push_idle(3);
    run_q("single", 0, -1, 0, -1);
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    bus.start = 1'b1;
    clr_hist();
    push_xfer(-1, 0, 0);
    run_q("rst_mid", 0, -1, 0, 19);
    clr_hist();
    push_idle(1);
    run_q("rst_mid_clear", 99, -1, 0, -1);
    rst = 1'b0;
    push_idle(4);
    run_q("rst_mid_nowr", 99, -1, 0, -1);
    test_single();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.start = 1'b1;
    clr_hist();
    push_xfer(-1, 0, 0);
    push_idle(1);
    push_xfer(-1, 0, 0);
    push_idle(3);
    run_q("back_to_back", 60, -1, 0, -1);
  endtask

`ifdef FFT_SEQ_STALL_EN
  task automatic test_stall();
    @(negedge clk);
    bus.start = 1'b1;
    clr_hist();
    push_xfer(2, 4, 3);
    push_idle(3);
    run_q("stall_run", 0, 2 * (NB + WL) + 4, 3, -1);
  endtask

  task automatic test_stall_ignored();
    @(negedge clk);
    bus.start = 1'b1;
    clr_hist();
    push_xfer(-1, 0, 0);
    push_idle(3);
    run_q("stall_drain", 0, NB, WL, -1);
    @(negedge clk);
    bus.start = 1'b1;
    clr_hist();
    push_xfer(-1, 0, 0);
    push_idle(3);
    run_q("stall_done", 0, NS * (NB + WL), 3, -1);
  endtask
`endif

  initial begin
    bus.start = 1'b0;
`ifdef FFT_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
    test_reset();
    test_single();
    test_midrun_reset();
    test_back_to_back();
`ifdef FFT_SEQ_STALL_EN
    test_stall();
    test_stall_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
